fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the 32×8 RAM. It holds the program counter and drives the RAM address. It captures the returned byte into an instruction register and presents it to the decode stage over a valid/ready handshake. It sustains one instruction per cycle, supports jumps with a pipeline flush, and stops on a HALT word.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/program_counter.sv | 26 ++
 rtl/fetch_unit.sv | 93 +++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit shared types and defaults.
// Sizes match the 32x8 instruction RAM.
package fetch_unit_pkg;

  localparam int DEF_WORDSIZE = 8;
  localparam int DEF_ADDR_SIZE = 5;
  localparam logic [7:0] DEF_HALT_WORD = 8'hFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Loadable up-counter for the fetch PC.
// Load wins over increment; wraps silently.
module program_counter
  import fetch_unit_pkg::*;
#(
  parameter int W = DEF_ADDR_SIZE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and a
// valid/ready handshake toward decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WORDSIZE = DEF_WORDSIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter logic [WORDSIZE-1:0] HALT_WORD =
    WORDSIZE'(DEF_HALT_WORD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_write_en,
  input  logic [WORDSIZE-1:0]  ram_data,
  input  logic                 jump_en,
  input  logic [ADDR_SIZE-1:0] jump_addr,
  output logic [WORDSIZE-1:0]  ir_out,
  output logic [ADDR_SIZE-1:0] ir_pc,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic                 halted
);

  fetch_state_t state, state_nx;
  logic [ADDR_SIZE-1:0] pc;
  logic load, inc, xfer;
  logic ir_halt, fill, stop;

  assign xfer = ir_valid & ir_ready;
  assign ir_halt = (ir_out == HALT_WORD);
  assign fill = (state == FULL) & xfer & ~ir_halt;
  assign stop = (state == FULL) & xfer & ir_halt;

  // A fetched HALT word parks the PC on itself.
  assign inc = load & (ram_data != HALT_WORD);

  program_counter #(
    .W(ADDR_SIZE)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (jump_en),
    .load_val (jump_addr),
    .inc      (inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load = 1'b0;
    unique case (1'b1)
      jump_en: begin
        state_nx = EMPTY;
      end
      !jump_en && (state == EMPTY): begin
        load = 1'b1;
        state_nx = FULL;
      end
      !jump_en && fill: begin
        load = 1'b1;
      end
      !jump_en && stop: begin
        state_nx = HALT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_out <= '0;
      ir_pc <= '0;
    end else if (load) begin
      ir_out <= ram_data;
      ir_pc <= pc;
    end
  end

  assign ram_addr = pc;
  assign ram_write_en = 1'b0;
  assign ir_valid = (state == FULL);
  assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: predicted
// fetch streams vs. observed handshakes.
module tb_fetch_unit;

  localparam int W = 8;
  localparam int A = 5;
  localparam int D = 32;
  localparam logic [W-1:0] HW = 8'hFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [A-1:0] ram_addr;
  logic ram_write_en;
  logic [W-1:0] ram_data;
  logic jump_en = 1'b0;
  logic [A-1:0] jump_addr = '0;
  logic [W-1:0] ir_out;
  logic [A-1:0] ir_pc;
  logic ir_valid;
  logic ir_ready = 1'b0;
  logic halted;

  logic [W-1:0] mem [D];
  assign ram_data = mem[ram_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ram_addr     (ram_addr),
    .ram_write_en (ram_write_en),
    .ram_data     (ram_data),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .ir_out       (ir_out),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .ir_ready     (ir_ready),
    .halted       (halted)
  );

  typedef struct packed {
    logic [A-1:0] pc;
    logic [W-1:0] ins;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  bit expect_halt = 0;
  logic [A-1:0] halt_pc;
  bit hold_chk = 0;
  logic [W-1:0] held_ir;
  logic [A-1:0] held_pc;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Program order from a start address: sequential
  // words, wrapping, ending with the first HALT word.
  function automatic void build(logic [A-1:0] start);
    int a;
    exp_t e;
    a = int'(start);
    q.delete();
    for (int i = 0; i < 40; i++) begin
      e.pc = a[A-1:0];
      e.ins = mem[a];
      q.push_back(e);
      if (mem[a] == HW) break;
      a = (a + 1) % D;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_chk = 0;
    end else begin
      chk("write_en", 32'(ram_write_en), 0);
      if (hold_chk && ir_valid) begin
        chk("hold_ir", 32'(ir_out), 32'(held_ir));
        chk("hold_pc", 32'(ir_pc), 32'(held_pc));
      end
      hold_chk = 0;
      if (expect_halt) begin
        chk("halted", 32'(halted), 1);
        chk("halt_valid", 32'(ir_valid), 0);
        chk("halt_addr", 32'(ram_addr), 32'(halt_pc));
      end
      if (ir_valid && ir_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL xfer: got pc %0h ins %0h want none",
                   ir_pc, ir_out);
        end else begin
          e = q.pop_front();
          chk("xfer_ir", 32'(ir_out), 32'(e.ins));
          chk("xfer_pc", 32'(ir_pc), 32'(e.pc));
          if (e.ins == HW) begin
            expect_halt = 1;
            halt_pc = e.pc;
          end
        end
      end else if (ir_valid) begin
        hold_chk = 1;
        held_ir = ir_out;
        held_pc = ir_pc;
      end
    end
  end

  task automatic step(bit rdy, bit jmp, logic [A-1:0] ja);
    ir_ready = rdy;
    jump_en = jmp;
    jump_addr = ja;
    @(posedge clk);
    #1;
    if (jmp) begin
      expect_halt = 0;
      build(ja);
    end
    jump_en = 1'b0;
  endtask

  initial begin
    int since;
    bit r, j;
    for (int i = 0; i < D; i++) mem[i] = 8'(8'h10 + i);

    #1;
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_ir", 32'(ir_out), 0);
    chk("rst_irpc", 32'(ir_pc), 0);
    build(0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 0, 0);
    chk("first_valid", 32'(ir_valid), 1);
    chk("first_ir", 32'(ir_out), 8'h10);
    step(1, 0, 0);
    chk("second_ir", 32'(ir_out), 8'h11);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("stall_ir", 32'(ir_out), 8'h11);
      chk("stall_pc", 32'(ir_pc), 1);
      chk("stall_addr", 32'(ram_addr), 2);
    end
    step(1, 0, 0);
    chk("resume_ir", 32'(ir_out), 8'h12);
    chk("resume_pc", 32'(ir_pc), 2);

    mem[31] = 8'h3A;
    mem[4] = HW;
    step(1, 1, 5'd31);
    chk("jmp_valid", 32'(ir_valid), 0);
    chk("jmp_addr", 32'(ram_addr), 31);
    step(1, 0, 0);
    chk("wrap_ir", 32'(ir_out), 8'h3A);
    chk("wrap_pc", 32'(ir_pc), 31);
    step(1, 0, 0);
    chk("wrap_ir0", 32'(ir_out), 8'h10);
    chk("wrap_pc0", 32'(ir_pc), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("halt_ir", 32'(ir_out), 32'(HW));
    chk("halt_pc", 32'(ir_pc), 4);
    chk("halt_hold", 32'(ram_addr), 4);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("in_halt", 32'(halted), 1);
    step(1, 1, 5'd8);
    chk("unhalt", 32'(halted), 0);
    chk("unhalt_addr", 32'(ram_addr), 8);
    step(1, 0, 0);
    chk("resume8", 32'(ir_out), 8'h18);

    step(1, 1, 5'd5);
    step(1, 0, 0);
    chk("at5", 32'(ir_pc), 5);
    step(1, 1, 5'd20);
    chk("flush_valid", 32'(ir_valid), 0);
    step(1, 0, 0);
    chk("at20_ir", 32'(ir_out), 8'h24);
    chk("at20_pc", 32'(ir_pc), 20);

    step(1, 0, 0);
    step(1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ir_valid), 0);
    chk("arst_addr", 32'(ram_addr), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_ir", 32'(ir_out), 0);
    expect_halt = 0;
    build(0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    chk("arst_first", 32'(ir_out), 8'h10);
    chk("arst_fvalid", 32'(ir_valid), 1);

    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < D; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? HW : 8'($urandom);
    expect_halt = 0;
    build(0);
    @(negedge clk);
    rst_n = 1'b1;
    since = 0;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) != 0);
      j = ($urandom_range(0, 15) == 0) || (since >= 30) ||
          (expect_halt && $urandom_range(0, 2) == 0);
      step(r, j, A'($urandom));
      since = j ? 0 : since + 1;
    end

    step(0, 0, 0);
    step(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
